alu_arbiter: RTL and testbench

- Shares one combinational ALU32 instance between two requesters (e.g. the execute stage and a multi-cycle multiply/divide helper).
- Accepts one operation at a time, using round-robin arbitration and a valid/ready handshake.
- Drives registered operands and opcode into the ALU, captures result and zero flag, and returns them on a per-requester response channel.
- Instantiated beside ALU32; the ALU ports connect directly to the alu_* ports.

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// One operation in flight: accept in IDLE, sample the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req0_opcode,
    input  logic [OPW-1:0]   req1_opcode,
    input  logic [WIDTH-1:0] req0_rega,
    input  logic [WIDTH-1:0] req1_rega,
    input  logic [WIDTH-1:0] req0_regb,
    input  logic [WIDTH-1:0] req1_regb,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp0_zero,
    output logic             rsp1_zero,
    output logic             rsp0_err,
    output logic             rsp1_err,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_rega,
    output logic [WIDTH-1:0] alu_regb,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam logic [OPW-1:0] OP_MAX = OPW'(5);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             sel_c, any_c, illegal_c, zero_c;
    logic [WIDTH-1:0] res_c;
    logic [OPW-1:0]   op_d;
    logic [WIDTH-1:0] a_d, b_d;
    logic             v0_d, v1_d, z0_d, z1_d, e0_d, e1_d;
    logic [WIDTH-1:0] r0_d, r1_d;

    // Next-state, arbitration and response capture
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        op_d       = alu_opcode;
        a_d        = alu_rega;
        b_d        = alu_regb;
        v0_d       = rsp0_valid;
        v1_d       = rsp1_valid;
        r0_d       = rsp0_result;
        r1_d       = rsp1_result;
        z0_d       = rsp0_zero;
        z1_d       = rsp1_zero;
        e0_d       = rsp0_err;
        e1_d       = rsp1_err;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        any_c = req0_valid | req1_valid;
        // Under contention the requester not served last wins
        sel_c = (req0_valid && req1_valid) ? ~last_q : req1_valid;

        // Illegal opcodes bypass the ALU with a fixed zero result
        illegal_c = alu_opcode > OP_MAX;
        res_c     = illegal_c ? '0 : alu_result;
        zero_c    = illegal_c | alu_zero;

        case (state_q)
            IDLE: begin
                if (any_c && rst_n) begin
                    req0_ready = ~sel_c;
                    req1_ready = sel_c;
                    grant_d    = sel_c;
                    op_d       = sel_c ? req1_opcode : req0_opcode;
                    a_d        = sel_c ? req1_rega : req0_rega;
                    b_d        = sel_c ? req1_regb : req0_regb;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (grant_q) begin
                    v1_d = 1'b1;
                    r1_d = res_c;
                    z1_d = zero_c;
                    e1_d = illegal_c;
                end else begin
                    v0_d = 1'b1;
                    r0_d = res_c;
                    z0_d = zero_c;
                    e0_d = illegal_c;
                end
                state_d = RESP;
            end
            RESP: begin
                if (grant_q ? rsp1_ready : rsp0_ready) begin
                    v0_d    = 1'b0;
                    v1_d    = 1'b0;
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            alu_opcode  <= '0;
            alu_rega    <= '0;
            alu_regb    <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp1_zero   <= 1'b0;
            rsp0_err    <= 1'b0;
            rsp1_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            alu_opcode  <= op_d;
            alu_rega    <= a_d;
            alu_regb    <= b_d;
            rsp0_valid  <= v0_d;
            rsp1_valid  <= v1_d;
            rsp0_result <= r0_d;
            rsp1_result <= r1_d;
            rsp0_zero   <= z0_d;
            rsp1_zero   <= z1_d;
            rsp0_err    <= e0_d;
            rsp1_err    <= e1_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, hand-built corner sequences and a randomized
// two-requester run checked against a transaction-level expectation model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err;
    logic [2:0]  req_opcode [2];
    logic [31:0] req_rega [2];
    logic [31:0] req_regb [2];
    logic [31:0] rsp_result [2];
    logic [2:0]  alu_opcode;
    logic [31:0] alu_rega, alu_regb, alu_result;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req1_valid(req_valid[1]),
        .req0_ready(req_ready[0]), .req1_ready(req_ready[1]),
        .req0_opcode(req_opcode[0]), .req1_opcode(req_opcode[1]),
        .req0_rega(req_rega[0]), .req1_rega(req_rega[1]),
        .req0_regb(req_regb[0]), .req1_regb(req_regb[1]),
        .rsp0_valid(rsp_valid[0]), .rsp1_valid(rsp_valid[1]),
        .rsp0_ready(rsp_ready[0]), .rsp1_ready(rsp_ready[1]),
        .rsp0_result(rsp_result[0]), .rsp1_result(rsp_result[1]),
        .rsp0_zero(rsp_zero[0]), .rsp1_zero(rsp_zero[1]),
        .rsp0_err(rsp_err[0]), .rsp1_err(rsp_err[1]),
        .alu_opcode(alu_opcode), .alu_rega(alu_rega), .alu_regb(alu_regb),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Stand-in for ALU32; illegal opcodes produce junk the arbiter must mask
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_result = alu_rega + alu_regb;
            3'd1:    alu_result = alu_rega - alu_regb;
            3'd2:    alu_result = alu_rega & alu_regb;
            3'd3:    alu_result = alu_rega | alu_regb;
            3'd4:    alu_result = 32'(alu_rega < alu_regb);
            3'd5:    alu_result = 32'($signed(alu_rega) < $signed(alu_regb));
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    typedef struct {
        int          r;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.err = 1'b0;
        case (op)
            3'd0:    e.res = a + b;
            3'd1:    e.res = a - b;
            3'd2:    e.res = a & b;
            3'd3:    e.res = a | b;
            3'd4:    e.res = (a < b) ? 32'd1 : 32'd0;
            3'd5:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin e.res = 32'd0; e.err = 1'b1; end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_opcode[i] = 3'd0;
            req_rega[i]   = 32'd0;
            req_regb[i]   = 32'd0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Single isolated operation with the response taken immediately
    task automatic do_txn(input vec_t v);
        int o;
        o = 1 - v.r;
        req_opcode[v.r] = v.op;
        req_rega[v.r]   = v.a;
        req_regb[v.r]   = v.b;
        req_valid       = 2'b00;
        req_valid[v.r]  = 1'b1;
        rsp_ready       = 2'b11;
        #1;
        chk("txn_ready", 32'(req_ready[v.r]), 32'd1);
        chk("txn_other_ready", 32'(req_ready[o]), 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("txn_exec_novalid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("txn_rsp_valid", 32'(rsp_valid[v.r]), 32'd1);
        chk("txn_other_valid", 32'(rsp_valid[o]), 32'd0);
        chk("txn_result", rsp_result[v.r], v.res);
        chk("txn_zero", 32'(rsp_zero[v.r]), 32'(v.zero));
        chk("txn_err", 32'(rsp_err[v.r]), 32'(v.err));
        @(posedge clk); #1;
        chk("txn_rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("txn_alu_hold", alu_rega, v.a);
    endtask

    vec_t vecs[9];
    int   grants[$];
    exp_t q0[$];
    exp_t q1[$];
    bit   pend[2];
    bit   acc[2];
    int   last_served;
    exp_t e;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 3'd0, 32'd1,          32'd1, 32'd2, 1'b0, 1'b0};
        vecs[1] = '{1, 3'd1, 32'd2,          32'd2, 32'd0, 1'b1, 1'b0};
        vecs[2] = '{0, 3'd7, 32'd3,          32'd4, 32'd0, 1'b1, 1'b1};
        vecs[3] = '{0, 3'd3, 32'd4,          32'd1, 32'd5, 1'b0, 1'b0};
        vecs[4] = '{1, 3'd2, 32'd5,          32'd1, 32'd1, 1'b0, 1'b0};
        vecs[5] = '{1, 3'd5, 32'hFFFF_FFFF,  32'd0, 32'd1, 1'b0, 1'b0};
        vecs[6] = '{0, 3'd4, 32'd5,          32'd4, 32'd0, 1'b1, 1'b0};
        vecs[7] = '{1, 3'd6, 32'd0,          32'd0, 32'd0, 1'b1, 1'b1};
        vecs[8] = '{0, 3'd0, 32'hFFFF_FFFF,  32'd1, 32'd0, 1'b1, 1'b0};

        // Reset values
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        chk("rst_flags", 32'({req_ready, rsp_valid, rsp_zero, rsp_err}), 32'd0);
        chk("rst_result0", rsp_result[0], 32'd0);
        chk("rst_result1", rsp_result[1], 32'd0);
        chk("rst_alu", 32'(alu_opcode) | alu_rega | alu_regb, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        foreach (vecs[i]) do_txn(vecs[i]);

        // Continuous contention alternates 0,1,0,1 from a fresh reset
        do_reset();
        req_opcode[0] = 3'd5; req_rega[0] = 32'hFFFF_FFFF; req_regb[0] = 32'd0;
        req_opcode[1] = 3'd4; req_rega[1] = 32'd5;         req_regb[1] = 32'd4;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready[0]) grants.push_back(0);
            if (req_ready[1]) grants.push_back(1);
            if (rsp_valid[0]) begin
                chk("alt_rsp0_result", rsp_result[0], 32'd1);
                chk("alt_rsp0_zero", 32'(rsp_zero[0]), 32'd0);
            end
            if (rsp_valid[1]) begin
                chk("alt_rsp1_result", rsp_result[1], 32'd0);
                chk("alt_rsp1_zero", 32'(rsp_zero[1]), 32'd1);
            end
            @(posedge clk);
            if (grants.size() >= 4) break;
        end
        #1 req_valid = 2'b00;
        chk("alt_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("alt_grant_order", 32'(grants[i]), 32'(i % 2));
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure on rsp0 while req1 waits
        req_opcode[0] = 3'd0; req_rega[0] = 32'd1; req_regb[0] = 32'd1;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        #1 chk("bp_accept0", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_opcode[1] = 3'd3; req_rega[1] = 32'd4; req_regb[1] = 32'd1;
        req_valid[1] = 1'b1;
        chk("bp_exec_ready1", 32'(req_ready[1]), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp_hold_result", rsp_result[0], 32'd2);
            chk("bp_hold_flags", 32'({rsp_zero[0], rsp_err[0]}), 32'd0);
            chk("bp_req1_blocked", 32'(req_ready[1]), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        #1 chk("bp_req1_blocked_resp", 32'(req_ready[1]), 32'd0);
        @(posedge clk); #1;
        chk("bp_rsp0_cleared", 32'(rsp_valid[0]), 32'd0);
        chk("bp_req1_granted", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        chk("bp_rsp1_valid", 32'(rsp_valid), 32'd2);
        chk("bp_rsp1_result", rsp_result[1], 32'd5);
        @(posedge clk); #1;

        // Reset during EXEC drops the operation
        req_opcode[1] = 3'd2; req_rega[1] = 32'd5; req_regb[1] = 32'd1;
        req_valid = 2'b10;
        #1 chk("mid_accept1", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", 32'({req_ready, rsp_valid, rsp_zero, rsp_err}), 32'd0);
        chk("mid_rst_results", rsp_result[0] | rsp_result[1], 32'd0);
        chk("mid_rst_alu", 32'(alu_opcode) | alu_rega | alu_regb, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_no_rsp1", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("mid_no_rsp1_after", 32'(rsp_valid), 32'd0);
        req_opcode[0] = 3'd3; req_rega[0] = 32'd4; req_regb[0] = 32'd1;
        req_valid = 2'b11;
        #1 chk("mid_first_contention", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("mid_rsp0_valid", 32'(rsp_valid), 32'd1);
        chk("mid_rsp0_result", rsp_result[0], 32'd5);
        @(posedge clk); #1;

        // Randomized traffic against the transaction model
        do_reset();
        last_served = 1;
        pend = '{1'b0, 1'b0};
        acc  = '{1'b0, 1'b0};
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) begin
                    pend[r] = 1'b0;
                    req_valid[r] = 1'b0;
                    acc[r] = 1'b0;
                end
                if (cyc < 1400 && !pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    req_opcode[r] = 3'($urandom_range(0, 7));
                    req_rega[r] = $urandom;
                    req_regb[r] = ($urandom_range(0, 3) == 0) ? req_rega[r] : $urandom;
                    req_valid[r] = 1'b1;
                end
                rsp_ready[r] = (cyc >= 1400) || ($urandom_range(0, 3) != 0);
            end
            #1;
            if (req_ready == 2'b11) chk("rnd_single_ready", 32'(req_ready), 32'd1);
            for (int r = 0; r < 2; r++) begin
                if (req_ready[r]) begin
                    chk("rnd_ready_needs_valid", 32'(pend[r]), 32'd1);
                    chk("rnd_idle_only", 32'(q0.size() + q1.size()), 32'd0);
                    if (pend[0] && pend[1]) chk("rnd_round_robin", 32'(r), 32'(1 - last_served));
                    e = model(req_opcode[r], req_rega[r], req_regb[r]);
                    if (r == 0) q0.push_back(e); else q1.push_back(e);
                    acc[r] = 1'b1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (rsp_valid[r]) begin
                    if ((r == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("rnd_spurious_rsp", 32'(r), 32'hFFFF_FFFF);
                    end else begin
                        e = (r == 0) ? q0[0] : q1[0];
                        chk("rnd_result", rsp_result[r], e.res);
                        chk("rnd_zero_err", 32'({rsp_zero[r], rsp_err[r]}), 32'({e.zero, e.err}));
                        if (rsp_ready[r]) begin
                            if (r == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                            last_served = r;
                        end
                    end
                end
            end
            if (cyc >= 1400 && q0.size() == 0 && q1.size() == 0 && !pend[0] && !pend[1]) break;
        end
        chk("rnd_drained", 32'(q0.size() + q1.size() + 32'(pend[0]) + 32'(pend[1])), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
